// File: rtl/sokoban_move_history_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sokoban_move_history_pkg
// Purpose  : Shared move-direction encoding and record-layout helpers for the
//            undo-history buffer and its users.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sokoban_move_history_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // A history record is {dir[1:0], box, pos[POS_W-1:0]}.
  function automatic int rec_w(input int pos_w);
    return pos_w + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sokoban_move_history_if.sv
`default_nettype none
// ============================================================================
// Module   : sokoban_move_history_if
// Purpose  : Bundle of the push/pop/status signals between the game core
//            (master) and the undo-history buffer (slave).
// Ports    : master drives clear, push_*, pop_req, step_limit;
//            slave drives pop_*, count, empty, full, overflowed, step,
//            limit_hit.
// Revision : 1.0 - initial release
// ============================================================================
interface sokoban_move_history_if #(
  parameter int POS_W  = 6,
  parameter int STEP_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clear;
  logic              push_valid;
  logic [1:0]        push_dir;
  logic              push_box;
  logic [POS_W-1:0]  push_pos;
  logic              pop_req;
  logic              pop_valid;
  logic              pop_nack;
  logic [1:0]        pop_dir;
  logic              pop_box;
  logic [POS_W-1:0]  pop_pos;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflowed;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] step_limit;
  logic              limit_hit;

  modport master (
    output clear, push_valid, push_dir, push_box, push_pos, pop_req, step_limit,
    input  pop_valid, pop_nack, pop_dir, pop_box, pop_pos, count, empty, full,
           overflowed, step, limit_hit
  );

  modport slave (
    input  clear, push_valid, push_dir, push_box, push_pos, pop_req, step_limit,
    output pop_valid, pop_nack, pop_dir, pop_box, pop_pos, count, empty, full,
           overflowed, step, limit_hit
  );

endinterface
`default_nettype wire

// File: rtl/sokoban_move_history_ram.sv
`default_nettype none
// ============================================================================
// Module   : sokoban_move_history_ram
// Purpose  : DEPTH x WIDTH register array holding past move records.
//            One write port; read data is registered and only updated on a
//            read strobe, so it holds the last popped record.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            we_i/waddr_i/wdata_i - write port
//            re_i/raddr_i  - read strobe and address
//            rdata_o       - registered read data (0 after reset)
// Revision : 1.0 - initial release
// ============================================================================
module sokoban_move_history_ram
  import sokoban_move_history_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = rec_w(6)
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     we_i,
  input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
  input  wire logic [WIDTH-1:0]         wdata_i,
  input  wire logic                     re_i,
  input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic      [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sokoban_move_history.sv
`default_nettype none
// ============================================================================
// Module   : sokoban_move_history
// Purpose  : DEPTH-entry undo ring for the sokoban core. Each accepted move is
//            pushed; each rising edge of pop_req pops the newest record. Keeps
//            a saturating step counter and a step-limit lose flag.
// Ports    : clk, reset - clock, synchronous active-high reset
//            bus        - slave side of sokoban_move_history_if
// Revision : 1.0 - initial release
// ============================================================================
module sokoban_move_history
  import sokoban_move_history_pkg::*;
#(
  parameter int POS_W  = 6,
  parameter int DEPTH  = 16,
  parameter int STEP_W = 8
) (
  input wire logic               clk,
  input wire logic               reset,
  sokoban_move_history_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int REC_W = rec_w(POS_W);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              ovf_q, ovf_d;
  logic              pop_req_q;
  logic              pop_valid_q;
  logic              pop_nack_q;
  logic              limit_hit_q;

  logic [PTR_W-1:0]  w_ptr_inc;
  logic [PTR_W-1:0]  w_ptr_dec;
  logic              w_empty;
  logic              w_full;
  logic              w_pop_edge;
  logic              w_pop_try;
  logic              w_pop_ok;
  logic [REC_W-1:0]  w_wdata;
  logic [REC_W-1:0]  w_rdata;

  // DEPTH need not be a power of two, so wrap the pointer explicitly.
  assign w_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  assign w_ptr_dec = (wr_ptr_q == '0) ? PTR_W'(DEPTH - 1) : wr_ptr_q - PTR_W'(1);

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_W'(DEPTH));

  // A pop edge is consumed even when clear or push wins the cycle, so a held
  // pop_req never retriggers after the competing event goes away.
  assign w_pop_edge = bus.pop_req & ~pop_req_q;
  assign w_pop_try  = w_pop_edge & ~bus.clear & ~bus.push_valid;
  assign w_pop_ok   = w_pop_try & ~w_empty;

  assign w_wdata = {bus.push_dir, bus.push_box, bus.push_pos};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    step_d   = step_q;
    ovf_d    = ovf_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      count_d  = '0;
      step_d   = '0;
      ovf_d    = 1'b0;
    end else if (bus.push_valid) begin
      wr_ptr_d = w_ptr_inc;
      // When full, the write lands on the oldest slot and count stays put.
      if (w_full) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
      if (step_q != '1) begin
        step_d = step_q + STEP_W'(1);
      end
    end else if (w_pop_ok) begin
      wr_ptr_d = w_ptr_dec;
      count_d  = count_q - CNT_W'(1);
      if (step_q != '0) begin
        step_d = step_q - STEP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      step_q      <= '0;
      ovf_q       <= 1'b0;
      pop_req_q   <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_nack_q  <= 1'b0;
      limit_hit_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      step_q      <= step_d;
      ovf_q       <= ovf_d;
      pop_req_q   <= bus.pop_req;
      pop_valid_q <= w_pop_ok;
      pop_nack_q  <= w_pop_try & w_empty;
      limit_hit_q <= (bus.step_limit != '0) && (step_q >= bus.step_limit);
    end
  end

  // The read is issued at the newest entry in the pop cycle; data appears
  // alongside pop_valid one cycle later and holds until the next pop.
  sokoban_move_history_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (bus.push_valid & ~bus.clear),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_wdata),
    .re_i    (w_pop_ok),
    .raddr_i (w_ptr_dec),
    .rdata_o (w_rdata)
  );

  assign bus.pop_dir    = w_rdata[REC_W-1 -: 2];
  assign bus.pop_box    = w_rdata[POS_W];
  assign bus.pop_pos    = w_rdata[POS_W-1:0];
  assign bus.pop_valid  = pop_valid_q;
  assign bus.pop_nack   = pop_nack_q;
  assign bus.count      = count_q;
  assign bus.empty      = w_empty;
  assign bus.full       = w_full;
  assign bus.overflowed = ovf_q;
  assign bus.step       = step_q;
  assign bus.limit_hit  = limit_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_sokoban_move_history.sv
`default_nettype none
// ============================================================================
// Module   : tb_sokoban_move_history
// Purpose  : Self-checking bench for sokoban_move_history (DEPTH=4, POS_W=6,
//            STEP_W=8). A vector table drives one cycle per row; a queue
//            model of the history produces expected pop records.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sokoban_move_history;
  import sokoban_move_history_pkg::*;

  localparam int POS_W  = 6;
  localparam int STEP_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset;

  sokoban_move_history_if #(.POS_W(POS_W), .STEP_W(STEP_W), .DEPTH(DEPTH)) bus();

  sokoban_move_history #(.POS_W(POS_W), .DEPTH(DEPTH), .STEP_W(STEP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       push;
    logic [1:0] dir;
    logic       box;
    logic [5:0] pos;
    logic       pr;
    logic [7:0] lim;
    int         ecnt;
    int         estep;
  } vec_t;

  typedef struct {
    logic [1:0] dir;
    logic       box;
    logic [5:0] pos;
  } rec_t;

  typedef struct {
    logic nack;
    rec_t rec;
  } exp_t;

  vec_t vecs[$];
  rec_t hist[$];
  exp_t exp_q[$];
  int   m_step;
  logic m_ovf;
  logic m_pr_q;
  int   n_cmp;
  int   n_err;

  function automatic vec_t mk(logic clr, logic push, logic [1:0] dir, logic box,
                              logic [5:0] pos, logic pr, logic [7:0] lim,
                              int ecnt, int estep);
    vec_t v;
    v.rst = 1'b0; v.clr = clr; v.push = push; v.dir = dir; v.box = box;
    v.pos = pos; v.pr = pr; v.lim = lim; v.ecnt = ecnt; v.estep = estep;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Drive one cycle, advance the model, then check after the edge.
  task automatic apply(input vec_t v, input int idx);
    logic edge_seen;
    logic exp_lim;
    rec_t r;
    exp_t e;
    reset          = v.rst;
    bus.clear      = v.clr;
    bus.push_valid = v.push;
    bus.push_dir   = v.dir;
    bus.push_box   = v.box;
    bus.push_pos   = v.pos;
    bus.pop_req    = v.pr;
    bus.step_limit = v.lim;

    edge_seen = v.pr && !m_pr_q;
    exp_lim   = (v.lim != 0) && (m_step >= int'(v.lim));
    if (v.rst) begin
      hist.delete(); exp_q.delete();
      m_step = 0; m_ovf = 1'b0; m_pr_q = 1'b0; exp_lim = 1'b0;
    end else begin
      m_pr_q = v.pr;
      if (v.clr) begin
        hist.delete(); m_step = 0; m_ovf = 1'b0;
      end else if (v.push) begin
        r.dir = v.dir; r.box = v.box; r.pos = v.pos;
        hist.push_back(r);
        if (hist.size() > DEPTH) begin
          void'(hist.pop_front());
          m_ovf = 1'b1;
        end
        if (m_step < 255) m_step++;
      end else if (edge_seen) begin
        if (hist.size() > 0) begin
          e.nack = 1'b0; e.rec = hist.pop_back();
          if (m_step > 0) m_step--;
        end else begin
          e.nack = 1'b1; e.rec = '{2'd0, 1'b0, 6'd0};
        end
        exp_q.push_back(e);
      end
    end

    @(posedge clk);
    #1;
    if (idx >= 0) begin
      chk($sformatf("count[%0d]", idx), int'(bus.count), v.ecnt);
      chk($sformatf("step[%0d]", idx), int'(bus.step), v.estep);
    end
    chk($sformatf("empty[%0d]", idx), int'(bus.empty), int'(hist.size() == 0));
    chk($sformatf("full[%0d]", idx), int'(bus.full), int'(hist.size() == DEPTH));
    chk($sformatf("ovf[%0d]", idx), int'(bus.overflowed), int'(m_ovf));
    chk($sformatf("limit_hit[%0d]", idx), int'(bus.limit_hit), int'(exp_lim));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("pop_valid[%0d]", idx), int'(bus.pop_valid), int'(!e.nack));
      chk($sformatf("pop_nack[%0d]", idx), int'(bus.pop_nack), int'(e.nack));
      if (!e.nack) begin
        chk($sformatf("pop_pos[%0d]", idx), int'(bus.pop_pos), int'(e.rec.pos));
        chk($sformatf("pop_dir[%0d]", idx), int'(bus.pop_dir), int'(e.rec.dir));
        chk($sformatf("pop_box[%0d]", idx), int'(bus.pop_box), int'(e.rec.box));
      end
    end else begin
      chk($sformatf("no_pop_valid[%0d]", idx), int'(bus.pop_valid), 0);
      chk($sformatf("no_pop_nack[%0d]", idx), int'(bus.pop_nack), 0);
    end
  endtask

  initial begin
    vec_t v;
    n_cmp = 0; n_err = 0;
    m_step = 0; m_ovf = 1'b0; m_pr_q = 1'b0;
    reset = 1'b1;
    bus.clear = 1'b0; bus.push_valid = 1'b0; bus.push_dir = 2'd0;
    bus.push_box = 1'b0; bus.push_pos = '0; bus.pop_req = 1'b0;
    bus.step_limit = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_step", int'(bus.step), 0);
    chk("rst_pop_valid", int'(bus.pop_valid), 0);
    chk("rst_pop_nack", int'(bus.pop_nack), 0);
    chk("rst_pop_pos", int'(bus.pop_pos), 0);
    chk("rst_limit_hit", int'(bus.limit_hit), 0);
    reset = 1'b0;

    //               clr  push dir        box  pos    pr   lim  cnt step
    // pop on empty -> nack
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   0, 0));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   0, 0));
    // three pushes, pop_req held 3 cycles -> one pop
    vecs.push_back(mk(0, 1, DIR_RIGHT, 0, 6'o00, 0, 0,   1, 1));
    vecs.push_back(mk(0, 1, DIR_RIGHT, 1, 6'o01, 0, 0,   2, 2));
    vecs.push_back(mk(0, 1, DIR_DOWN,  0, 6'o02, 0, 0,   3, 3));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   2, 2));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   2, 2));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   2, 2));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   2, 2));
    // overflow and wrap
    vecs.push_back(mk(1, 0, DIR_UP,    0, 6'd0,  0, 0,   0, 0));
    vecs.push_back(mk(0, 1, DIR_UP,    0, 6'o10, 0, 0,   1, 1));
    vecs.push_back(mk(0, 1, DIR_LEFT,  1, 6'o11, 0, 0,   2, 2));
    vecs.push_back(mk(0, 1, DIR_DOWN,  0, 6'o12, 0, 0,   3, 3));
    vecs.push_back(mk(0, 1, DIR_RIGHT, 1, 6'o13, 0, 0,   4, 4));
    vecs.push_back(mk(0, 1, DIR_UP,    1, 6'o14, 0, 0,   4, 5));
    vecs.push_back(mk(0, 1, DIR_LEFT,  0, 6'o15, 0, 0,   4, 6));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   3, 5));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   3, 5));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   2, 4));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   2, 4));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   1, 3));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   1, 3));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   0, 2));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   0, 2));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   0, 2));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   0, 2));
    // step limit
    vecs.push_back(mk(1, 0, DIR_UP,    0, 6'd0,  0, 3,   0, 0));
    vecs.push_back(mk(0, 1, DIR_UP,    0, 6'o20, 0, 3,   1, 1));
    vecs.push_back(mk(0, 1, DIR_DOWN,  1, 6'o21, 0, 3,   2, 2));
    vecs.push_back(mk(0, 1, DIR_RIGHT, 0, 6'o22, 0, 3,   3, 3));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 3,   3, 3));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 3,   2, 2));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 3,   2, 2));
    vecs.push_back(mk(0, 1, DIR_LEFT,  1, 6'o23, 0, 0,   3, 3));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   3, 3));
    // push and pop edge together -> push wins
    vecs.push_back(mk(0, 1, DIR_LEFT,  0, 6'o24, 1, 0,   4, 4));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   4, 4));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   4, 4));
    // clear while pop_req held
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   3, 3));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   3, 3));
    vecs.push_back(mk(1, 0, DIR_UP,    0, 6'd0,  1, 0,   0, 0));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   0, 0));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   0, 0));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  1, 0,   0, 0));
    vecs.push_back(mk(0, 0, DIR_UP,    0, 6'd0,  0, 0,   0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Reset arriving together with a pop edge suppresses the pop.
    apply(mk(0, 1, DIR_DOWN, 1, 6'o33, 0, 0, 1, 1), 100);
    v = mk(0, 0, DIR_UP, 0, 6'd0, 1, 0, 0, 0);
    v.rst = 1'b1;
    apply(v, 101);
    chk("rstpop_pos", int'(bus.pop_pos), 0);
    apply(mk(0, 0, DIR_UP, 0, 6'd0, 0, 0, 0, 0), 102);
    apply(mk(0, 0, DIR_UP, 0, 6'd0, 1, 0, 0, 0), 103);
    apply(mk(0, 0, DIR_UP, 0, 6'd0, 0, 0, 0, 0), 104);

    // Popped fields hold after the pulse: push two, pop once, idle.
    apply(mk(0, 1, DIR_LEFT, 1, 6'o41, 0, 0, 1, 1), 105);
    apply(mk(0, 1, DIR_UP,   0, 6'o42, 0, 0, 2, 2), 106);
    apply(mk(0, 0, DIR_UP,   0, 6'd0,  1, 0, 1, 1), 107);
    apply(mk(0, 0, DIR_UP,   0, 6'd0,  0, 0, 1, 1), 108);
    chk("hold_pos", int'(bus.pop_pos), int'(6'o42));

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
